// File: rtl/fm_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fm_wb_pkg
// Purpose  : Shared types and constants for the feature-map write burster:
//            FSM state encoding, AXI burst/response codes, 4 KB page size
//            and bytes carried by one 256-bit beat.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fm_wb_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_AW   = 3'd2,
    S_W    = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0]  c_burst_incr     = 2'b01;
  localparam logic [1:0]  c_resp_okay      = 2'b00;
  localparam int unsigned c_boundary_4k    = 4096;
  localparam int unsigned c_bytes_per_beat = 32;

endpackage
`default_nettype wire

// File: rtl/fm_write_burster_if.sv
`default_nettype none
// ============================================================================
// Module   : fm_write_burster_if
// Purpose  : AXI4 write-address / write-data / write-response channel bundle.
// Ports    : m_aw* (address), m_w* (data), m_b* (response);
//            modport master = burster side, modport slave = memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface fm_write_burster_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   m_awaddr;
  logic [7:0]              m_awlen;
  logic [1:0]              m_awburst;
  logic                    m_awvalid;
  logic                    m_awready;
  logic [DATA_WIDTH-1:0]   m_wdata;
  logic [DATA_WIDTH/8-1:0] m_wstrb;
  logic                    m_wlast;
  logic                    m_wvalid;
  logic                    m_wready;
  logic [1:0]              m_bresp;
  logic                    m_bvalid;
  logic                    m_bready;

  modport master (
    output m_awaddr, m_awlen, m_awburst, m_awvalid,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_bready,
    input  m_awready, m_wready, m_bresp, m_bvalid
  );

  modport slave (
    input  m_awaddr, m_awlen, m_awburst, m_awvalid,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_bready,
    output m_awready, m_wready, m_bresp, m_bvalid
  );
endinterface
`default_nettype wire

// File: rtl/fm_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fm_wb_fifo
// Purpose  : Synchronous first-word-fall-through FIFO. The head word is
//            visible on data_o whenever the FIFO is not empty.
// Ports    : sys_clk, rst (sync, active-high)
//            push_i/data_i  : write side (dropped when full and not popping)
//            pop_i/data_o   : read side
//            count_o, full_o, empty_o : occupancy
//            ovf_o          : push attempted while full with no pop this cycle
// Revision : 1.0 - initial release
// ============================================================================
module fm_wb_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 32
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o
);
  localparam int c_aw = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [c_aw:0]      wr_ptr_q;
  logic [c_aw:0]      rd_ptr_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               w_push;
  logic               w_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                   (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | w_pop);
  assign ovf_o   = push_i & full_o & ~w_pop;
  assign data_o  = mem_q[rd_ptr_q[c_aw-1:0]];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) mem_q[wr_ptr_q[c_aw-1:0]] <= data_i;
  end
endmodule
`default_nettype wire

// File: rtl/fm_write_burster.sv
`default_nettype none
// ============================================================================
// Module   : fm_write_burster
// Purpose  : Buffers the width-converter output stream and writes it to
//            memory as AXI4 INCR bursts from a programmed base address,
//            never crossing a 4 KB page; pulses done once all bursts of the
//            job have been acknowledged.
// Ports    : sys_clk, rst (sync, active-high)
//            start_i, base_addr_i, word_total_i : job programming
//            data_in_i, valid_in_i              : input stream (no ready)
//            almost_full_o, overflow_o          : upstream flow status
//            busy_o, done_o, err_o              : job status
//            m_axi                              : AXI4 write master
// Revision : 1.0 - initial release
// ============================================================================
module fm_write_burster
  import fm_wb_pkg::*;
#(
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_DEPTH   = 32,
  parameter int AFULL_MARGIN = 4,
  parameter int CNT_WIDTH    = 20
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  word_total_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  valid_in_i,
  output logic                  almost_full_o,
  output logic                  overflow_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  fm_write_burster_if.master    m_axi
);
  localparam int c_fcw = $clog2(FIFO_DEPTH) + 1;
  localparam int c_bw  = 9;
  localparam logic [c_fcw-1:0] c_afull_level = c_fcw'(FIFO_DEPTH - AFULL_MARGIN);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [c_bw-1:0]       beats_q, beats_d;
  logic [c_bw-1:0]       beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;
  logic                  almost_full_q;
  logic                  overflow_q;

  logic [DATA_WIDTH-1:0] w_fifo_head;
  logic [c_fcw-1:0]      w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_fifo_ovf;
  logic                  w_pop;
  logic [c_bw-1:0]       w_room;
  logic [c_bw-1:0]       w_len_cap;
  logic [c_bw-1:0]       w_beats;

  fm_wb_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rst     (rst),
    .push_i  (valid_in_i),
    .data_i  (data_in_i),
    .pop_i   (w_pop),
    .data_o  (w_fifo_head),
    .count_o (w_fifo_count),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .ovf_o   (w_fifo_ovf)
  );

  // Beats left before the next 4 KB page: 1..128 for 32-byte beats.
  assign w_room = c_bw'((c_boundary_4k - 32'(addr_q[11:0])) / c_bytes_per_beat);

  always_comb begin
    w_len_cap = c_bw'(BURST_LEN);
    if (remaining_q < CNT_WIDTH'(BURST_LEN)) w_len_cap = c_bw'(remaining_q);
    w_beats = (w_room < w_len_cap) ? w_room : w_len_cap;
  end

  assign m_axi.m_wstrb   = '1;
  assign m_axi.m_awburst = c_burst_incr;
  assign almost_full_o   = almost_full_q;
  assign overflow_o      = overflow_q;
  assign err_o           = err_q;

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    remaining_d        = remaining_q;
    beats_d            = beats_q;
    beat_cnt_d         = beat_cnt_q;
    err_d              = err_q;
    w_pop              = 1'b0;
    busy_o             = 1'b1;
    done_o             = 1'b0;
    m_axi.m_awvalid    = 1'b0;
    m_axi.m_awaddr     = '0;
    m_axi.m_awlen      = '0;
    m_axi.m_wvalid     = 1'b0;
    m_axi.m_wdata      = '0;
    m_axi.m_wlast      = 1'b0;
    m_axi.m_bready     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          err_d = 1'b0;
          if (word_total_i == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d      = base_addr_i & ~ADDR_WIDTH'(31);
            remaining_d = word_total_i;
            state_d     = S_CALC;
          end
        end
      end
      S_CALC: begin
        // Only issue AW once the whole burst is buffered so W never stalls.
        if (32'(w_fifo_count) >= 32'(w_beats)) begin
          beats_d    = w_beats;
          beat_cnt_d = '0;
          state_d    = S_AW;
        end
      end
      S_AW: begin
        m_axi.m_awvalid = 1'b1;
        m_axi.m_awaddr  = addr_q;
        m_axi.m_awlen   = 8'(beats_q - 9'd1);
        if (m_axi.m_awready) state_d = S_W;
      end
      S_W: begin
        m_axi.m_wvalid = ~w_fifo_empty;
        m_axi.m_wdata  = w_fifo_head;
        m_axi.m_wlast  = (beat_cnt_q == beats_q - 9'd1);
        if (m_axi.m_wvalid && m_axi.m_wready) begin
          w_pop = 1'b1;
          if (m_axi.m_wlast) state_d = S_B;
          else               beat_cnt_d = beat_cnt_q + 9'd1;
        end
      end
      S_B: begin
        m_axi.m_bready = 1'b1;
        if (m_axi.m_bvalid) begin
          if (m_axi.m_bresp != c_resp_okay) err_d = 1'b1;
          addr_d      = addr_q + ADDR_WIDTH'(beats_q) * ADDR_WIDTH'(c_bytes_per_beat);
          remaining_d = remaining_q - CNT_WIDTH'(beats_q);
          state_d     = (remaining_q == CNT_WIDTH'(beats_q)) ? S_DONE : S_CALC;
        end
      end
      S_DONE: begin
        busy_o  = 1'b0;
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      beats_q       <= '0;
      beat_cnt_q    <= '0;
      err_q         <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      beats_q       <= beats_d;
      beat_cnt_q    <= beat_cnt_d;
      err_q         <= err_d;
      almost_full_q <= w_fifo_full | (w_fifo_count >= c_afull_level);
      if (w_fifo_ovf) overflow_q <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fm_write_burster.sv
`default_nettype none
// ============================================================================
// Module   : tb_fm_write_burster
// Purpose  : Self-checking bench for fm_write_burster. Expected AW and W
//            transfers are queued when a job is issued; a monitor pops and
//            compares them on every handshake. A memory model answers bursts
//            with B responses and applies configurable ready backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fm_write_burster;
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  typedef struct {
    logic [255:0] data;
    logic         last;
  } w_t;

  logic         sys_clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  base_addr;
  logic [19:0]  word_total;
  logic [255:0] data_in;
  logic         valid_in;
  logic         almost_full, overflow, busy, done, err;

  int  total = 0;
  int  bad   = 0;
  aw_t exp_aw[$];
  w_t  exp_w[$];
  int  exp_seq = 0;
  int  word_seq = 0;
  int  aw_count = 0;
  int  bp_mode = 0;
  int  bad_burst = -1;
  int  b_idx = 0;
  bit  wlast_hs = 1'b0;
  bit  b_hs = 1'b0;

  fm_write_burster_if #(.DATA_WIDTH(256), .ADDR_WIDTH(32)) axi ();

  fm_write_burster dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .start_i       (start),
    .base_addr_i   (base_addr),
    .word_total_i  (word_total),
    .data_in_i     (data_in),
    .valid_in_i    (valid_in),
    .almost_full_o (almost_full),
    .overflow_o    (overflow),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .m_axi         (axi)
  );

  initial forever #5 sys_clk = ~sys_clk;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] word_of(input int k);
    logic [255:0] w;
    for (int j = 0; j < 8; j++) w[j*32 +: 32] = 32'hA500_0000 + 32'(k * 8 + j);
    return w;
  endfunction

  task automatic expect_burst(input logic [31:0] addr, input int beats);
    aw_t a;
    w_t  w;
    a.addr = addr;
    a.len  = 8'(beats - 1);
    exp_aw.push_back(a);
    for (int i = 0; i < beats; i++) begin
      w.data = word_of(exp_seq);
      w.last = (i == beats - 1);
      exp_seq++;
      exp_w.push_back(w);
    end
  endtask

  // Upstream converter model: respects almost_full.
  task automatic push_words(input int n);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < n && guard < 5000) begin
      @(posedge sys_clk); #1;
      if (!almost_full) begin
        valid_in = 1'b1;
        data_in  = word_of(word_seq);
        word_seq++;
        k++;
      end else begin
        valid_in = 1'b0;
      end
      guard++;
    end
    @(posedge sys_clk); #1;
    valid_in = 1'b0;
    if (n != 0) check("push_count", k, n);
  endtask

  task automatic run_job(input logic [31:0] base, input int n, input int push_n,
                         output int aw_lat, output int done_cyc);
    int   cyc;
    logic busy1;
    aw_lat   = -1;
    done_cyc = -1;
    busy1    = 1'b0;
    fork
      push_words(push_n);
      begin
        @(posedge sys_clk); #1;
        start      = 1'b1;
        base_addr  = base;
        word_total = 20'(n);
        @(posedge sys_clk); #1;
        start = 1'b0;
        cyc = 0;
        while (done_cyc < 0 && cyc < 3000) begin
          @(negedge sys_clk);
          cyc++;
          if (cyc == 1) busy1 = busy;
          if (aw_lat < 0 && axi.m_awvalid) aw_lat = cyc;
          if (done) done_cyc = cyc;
        end
      end
    join
    check("done_seen", done_cyc > 0, 1'b1);
    if (n != 0) check("busy_during_job", busy1, 1'b1);
  endtask

  task automatic end_checks(input string tag, input logic exp_err);
    check($sformatf("%s_aw_left", tag), exp_aw.size(), 0);
    check($sformatf("%s_w_left", tag), exp_w.size(), 0);
    check($sformatf("%s_err", tag), err, exp_err);
    check($sformatf("%s_overflow", tag), overflow, 1'b0);
    check($sformatf("%s_busy_after", tag), busy, 1'b0);
  endtask

  // Memory-side model: ready generation and B responses.
  initial begin : slave
    int b_pending;
    b_pending     = 0;
    axi.m_awready = 1'b0;
    axi.m_wready  = 1'b0;
    axi.m_bvalid  = 1'b0;
    axi.m_bresp   = 2'd0;
    forever begin
      @(posedge sys_clk); #1;
      if (rst) begin
        b_pending    = 0;
        axi.m_bvalid = 1'b0;
        axi.m_bresp  = 2'd0;
      end else begin
        if (b_hs) begin
          axi.m_bvalid = 1'b0;
          axi.m_bresp  = 2'd0;
        end
        if (wlast_hs) b_pending++;
        if (!axi.m_bvalid && b_pending > 0) begin
          axi.m_bvalid = 1'b1;
          axi.m_bresp  = (b_idx == bad_burst) ? 2'd2 : 2'd0;
          b_idx++;
          b_pending--;
        end
      end
      case (bp_mode)
        1: begin
          axi.m_awready = 1'($urandom_range(0, 1));
          axi.m_wready  = 1'($urandom_range(0, 1));
        end
        2: begin
          axi.m_awready = 1'b1;
          axi.m_wready  = 1'b0;
        end
        default: begin
          axi.m_awready = 1'b1;
          axi.m_wready  = 1'b1;
        end
      endcase
    end
  end

  // Monitor: handshakes are decided by values stable at the falling edge.
  initial begin : monitor
    logic         aw_stall, w_stall;
    logic [31:0]  aw_a;
    logic [7:0]   aw_l;
    logic [255:0] w_d;
    logic         w_l;
    aw_t          ea;
    w_t           ew;
    aw_stall = 1'b0;
    w_stall  = 1'b0;
    forever begin
      @(negedge sys_clk);
      wlast_hs = 1'b0;
      b_hs     = 1'b0;
      if (rst) begin
        aw_stall = 1'b0;
        w_stall  = 1'b0;
      end else begin
        if (aw_stall) begin
          check("aw_hold_valid", axi.m_awvalid, 1'b1);
          check("aw_hold_addr", axi.m_awaddr, aw_a);
          check("aw_hold_len", axi.m_awlen, aw_l);
        end
        if (w_stall) begin
          check("w_hold_valid", axi.m_wvalid, 1'b1);
          check("w_hold_data", axi.m_wdata, w_d);
          check("w_hold_last", axi.m_wlast, w_l);
        end
        if (axi.m_awvalid && axi.m_awready) begin
          aw_count++;
          if (exp_aw.size() == 0) begin
            check("aw_unexpected", exp_aw.size(), 1);
          end else begin
            ea = exp_aw.pop_front();
            check("aw_addr", axi.m_awaddr, ea.addr);
            check("aw_len", axi.m_awlen, ea.len);
          end
        end
        if (axi.m_wvalid && axi.m_wready) begin
          if (exp_w.size() == 0) begin
            check("w_unexpected", exp_w.size(), 1);
          end else begin
            ew = exp_w.pop_front();
            check("w_data", axi.m_wdata, ew.data);
            check("w_last", axi.m_wlast, ew.last);
            check("w_strb", axi.m_wstrb, 32'hFFFF_FFFF);
          end
          if (axi.m_wlast) wlast_hs = 1'b1;
        end
        if (axi.m_bvalid && axi.m_bready) b_hs = 1'b1;
        aw_stall = axi.m_awvalid && !axi.m_awready;
        aw_a     = axi.m_awaddr;
        aw_l     = axi.m_awlen;
        w_stall  = axi.m_wvalid && !axi.m_wready;
        w_d      = axi.m_wdata;
        w_l      = axi.m_wlast;
      end
    end
  end

  initial begin : main
    int  aw_lat, done_cyc, aw_before;
    aw_t a;
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_total = '0;
    data_in    = '0;
    valid_in   = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_awvalid", axi.m_awvalid, 1'b0);
    check("rst_awaddr", axi.m_awaddr, 32'h0);
    check("rst_awlen", axi.m_awlen, 8'h0);
    check("rst_wvalid", axi.m_wvalid, 1'b0);
    check("rst_wdata", axi.m_wdata, 256'h0);
    check("rst_wlast", axi.m_wlast, 1'b0);
    check("rst_bready", axi.m_bready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_almost_full", almost_full, 1'b0);
    @(posedge sys_clk); #1;
    rst = 1'b0;

    // Zero-length job: done without any AW.
    aw_before = aw_count;
    run_job(32'h0, 0, 0, aw_lat, done_cyc);
    check("zero_done_latency_ok", (done_cyc >= 1 && done_cyc <= 2), 1'b1);
    check("zero_no_aw", aw_count, aw_before);
    check("zero_busy", busy, 1'b0);

    // 36 words from 0x1000, no backpressure.
    bp_mode = 0; b_idx = 0;
    expect_burst(32'h1000, 16);
    expect_burst(32'h1200, 16);
    expect_burst(32'h1400, 4);
    aw_before = aw_count;
    run_job(32'h1000, 36, 36, aw_lat, done_cyc);
    end_checks("jobA", 1'b0);
    check("jobA_aw_count", aw_count - aw_before, 3);

    // 16 words from 0x1F00, prefilled: split at the 4 KB page.
    expect_burst(32'h1F00, 8);
    expect_burst(32'h2000, 8);
    push_words(16);
    b_idx = 0;
    run_job(32'h1F00, 16, 0, aw_lat, done_cyc);
    check("jobB_start_to_aw", aw_lat, 2);
    end_checks("jobB", 1'b0);

    // 40 words with random AW/W backpressure.
    bp_mode = 1; b_idx = 0;
    expect_burst(32'h3000, 16);
    expect_burst(32'h3200, 16);
    expect_burst(32'h3400, 8);
    run_job(32'h3000, 40, 40, aw_lat, done_cyc);
    end_checks("jobC", 1'b0);

    // SLVERR on the second of three bursts.
    bp_mode = 0; b_idx = 0; bad_burst = 1;
    expect_burst(32'h4000, 16);
    expect_burst(32'h4200, 16);
    expect_burst(32'h4400, 16);
    run_job(32'h4000, 48, 48, aw_lat, done_cyc);
    end_checks("jobD", 1'b1);
    bad_burst = -1;
    repeat (3) @(negedge sys_clk);
    check("err_sticky", err, 1'b1);
    run_job(32'h0, 0, 0, aw_lat, done_cyc);
    check("err_cleared_by_start", err, 1'b0);

    // Fill with no job: almost_full lags count by one cycle; 33rd word overflows.
    for (int i = 1; i <= 33; i++) begin
      @(posedge sys_clk); #1;
      if (i == 29) check("afull_at_count28", almost_full, 1'b0);
      if (i == 30) check("afull_after_count28", almost_full, 1'b1);
      if (i == 33) check("ovf_before_33rd", overflow, 1'b0);
      valid_in = 1'b1;
      data_in  = word_of(word_seq);
      word_seq++;
    end
    @(posedge sys_clk); #1;
    valid_in = 1'b0;
    check("ovf_after_33rd", overflow, 1'b1);
    check("afull_full", almost_full, 1'b1);

    // Reset while W is stalled.
    bp_mode = 2; b_idx = 0;
    a.addr = 32'h5000;
    a.len  = 8'd15;
    exp_aw.push_back(a);
    @(posedge sys_clk); #1;
    start = 1'b1; base_addr = 32'h5000; word_total = 20'd20;
    @(posedge sys_clk); #1;
    start = 1'b0;
    done_cyc = 0;
    for (int c = 0; c < 20 && done_cyc == 0; c++) begin
      @(negedge sys_clk);
      if (axi.m_wvalid) done_cyc = 1;
    end
    check("midw_reached", done_cyc, 1);
    @(posedge sys_clk); #1;
    rst = 1'b1;
    @(posedge sys_clk); #1;
    check("midw_rst_awvalid", axi.m_awvalid, 1'b0);
    check("midw_rst_wvalid", axi.m_wvalid, 1'b0);
    check("midw_rst_wlast", axi.m_wlast, 1'b0);
    check("midw_rst_wdata", axi.m_wdata, 256'h0);
    check("midw_rst_bready", axi.m_bready, 1'b0);
    check("midw_rst_busy", busy, 1'b0);
    check("midw_rst_done", done, 1'b0);
    check("midw_rst_overflow", overflow, 1'b0);
    check("midw_rst_afull", almost_full, 1'b0);
    check("midw_aw_seen", exp_aw.size(), 0);
    bp_mode = 0;
    @(posedge sys_clk); #1;
    rst = 1'b0;

    // FIFO must be empty after reset: a fresh job sees only new data.
    exp_seq = word_seq;
    b_idx = 0;
    expect_burst(32'h6000, 4);
    run_job(32'h6000, 4, 4, aw_lat, done_cyc);
    end_checks("jobE", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
